// File: rtl/dmem_resp.sv
// dmem_resp -- multicycle data-memory responder.
//
// Accepts one word request at a time over a valid/ready handshake, waits
// LATENCY clock edges, then presents a response that is held until the
// initiator consumes it. Writes commit to the array when the response is
// produced. Reads return the stored word. The response to a write echoes the
// word that was written.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  edges from the accepting edge to resp_valid_o rising (1..15)
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   req_valid_i   request present
//   req_ready_o   request can be accepted this cycle (state is IDLE)
//   we_i          1 = write, 0 = read (sampled at accept)
//   addr_i32      byte address (sampled at accept)
//   wdata_i32     write data (sampled at accept)
//   resp_valid_o  response available
//   resp_ready_i  response consumed
//   rdata_o32     read data, or the written word for writes
//   err_o         response error flag
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   When defined, a request with addr_i32[1:0] != 0 completes with err_o=1 and
//   rdata_o32=0, and its write is suppressed. When it is undefined, the low
//   address bits are ignored and err_o stays 0.

module dmem_resp #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] wdata_i32,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] rdata_o32,
  output logic        err_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                mis_q;
  logic                resp_valid_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem_q [DEPTH];

  logic                mis_d;
  logic                fill;
  logic                mem_we;
  logic                unused_addr_bits;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_d = (addr_i32[1:0] != 2'b00);
`else
  assign mis_d = 1'b0;
`endif

  // Upper bits alias modulo DEPTH*4. Bits [1:0] only matter when the trap
  // is enabled.
  assign unused_addr_bits = ^{addr_i32[31:ADDR_W+2], addr_i32[1:0]};

  // The first edge spent in RESP produces the response. This places the
  // rise of resp_valid_o exactly LATENCY edges after the accepting edge.
  assign fill   = (state_q == RESP) && !resp_valid_q;
  assign mem_we = fill && we_q && !mis_q && !reset_i;

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign rdata_o32    = rdata_q;
  assign err_o        = err_q;

  // The array has no reset. A reset at the commit edge drops the write.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i32[ADDR_W+1:2];
            wdata_q <= wdata_i32;
            mis_q   <= mis_d;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            err_q        <= mis_q;
            if (mis_q) begin
              rdata_q <= '0;
            end else if (we_q) begin
              rdata_q <= wdata_q;
            end else begin
              rdata_q <= mem_q[idx_q];
            end
          end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
